accum5: RTL and testbench
=========================

// Module: accum5
// PURPOSE
//   4-bit registered ALU/accumulator slice: selects one of 16 operations on operands a, b.
//   The result and overflow flag are captured on every rising clock edge.
//   Sits in the datapath as a single-stage execute unit; r/of are register outputs only.
//   Accumulate modes use the registered r as an operand.
// PARAMETERS
//   none (data width fixed at 4 bits)
// PORTS
//   Clk     in   1  clock; all state updates on rising edge
//   nReset  in   1  asynchronous, active-low reset
//   a       in   4  operand A (unsigned)
//   b       in   4  operand B (unsigned)
//   cin     in   1  carry-in / borrow-in / shift fill bit
//   m       in   4  operation select (see BEHAVIOUR)
//   r       out  4  registered result
//   of      out  1  registered overflow/carry/borrow/shift-out flag
//   Positional port order: (r, of, a, b, cin, m, Clk, nReset)
// BEHAVIOUR
//   - One clock. Reset is asynchronous and active-low: nReset=0 forces r=4'b0000, of=0
//     immediately, independent of Clk; held while low.
//   - First capture is on the first rising Clk edge after nReset deasserts.
//   - Latency 1 cycle: inputs sampled at rising edge n appear on r/of after edge n.
//   - No handshake; a new op every cycle. Outputs change only on Clk edges or reset.
//   - All arithmetic is unsigned, modulo 16. of reflects the op captured in the same edge.
//   - Op table (m) -> r_next ; of_next:
//     0 ADD  : a+b+cin          ; carry out of bit 3
//     1 SUB  : a-b-cin          ; borrow (1 when a < b+cin)
//     2 CMP  : {0, lt, gt, eq}  ; 0   (r[0]=a==b, r[1]=a>b, r[2]=a<b, r[3]=0; cin ignored)
//     3 AND  : a&b              ; 0
//     4 OR   : a|b              ; 0
//     5 XOR  : a^b              ; 0
//     6 NOT  : ~a               ; 0
//     7 PASS : a                ; 0
//     8 ACCA : r+a+cin          ; carry out (r = current registered value)
//     9 ACCS : r-a-cin          ; borrow
//     10 SHL : {a[2:0],cin}     ; a[3]
//     11 SHR : {cin,a[3:1]}     ; a[0]
//     12 INC : a+1              ; carry (1 only when a=4'hF)
//     13 DEC : a-1              ; borrow (1 only when a=4'h0)
//     14 HOLD: r unchanged      ; of unchanged
//     15 CLR : 4'b0000          ; 0
//   - Wrap-around: ADD/ACCA/INC wrap to low 4 bits with of=1; SUB/ACCS/DEC wrap modulo 16 with of=1.
//   - Logic/CMP/PASS/CLR always clear of.
//   - Reset asserted mid-sequence overrides any op, including HOLD and accumulate.
//   - X/Z on m is not supported; any defined m value is legal. No unused codes.
// TESTING
//   ADD: a=1111 b=0001 cin=0 m=0 -> after edge r=0000 of=1;
//        a=1010 b=0101 -> r=1111 of=0; a=0111 b=1100 -> r=0011 of=1
//   SUB: a=1111 b=1001 m=1 -> r=0110 of=0; a=1010 b=0101 -> r=0101 of=0;
//        a=0111 b=1100 -> r=1011 of=1
//   CMP: a=1001 b=0001 m=2 -> r=0010; a=1010 b=0101 -> r=0010;
//        a=0111 b=1100 -> r=0100; a=b=0011 -> r=0001; of=0 in all
//   AND: a=1001 b=0001 m=3 -> r=0001; a=1010 b=0101 -> r=0000; a=0111 b=1100 -> r=0100
//   ACCA: CLR, then m=8 a=0101 cin=0 for 4 edges -> r=0101,1010,1111,0100 (of=1 on 4th);
//        then m=14 -> r holds 0100
//   Reset: pulse nReset low between edges while r=1111 -> r=0000, of=0 immediately;
//        next op resumes on the first edge after release

Source files
------------

// File: rtl/accum5.sv
// accum5: 4-bit registered ALU/accumulator slice.
// Sixteen ops on a/b (or on the registered r); result and flag registered.
module accum5 (
    output logic [3:0] r,
    output logic       of,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic [3:0] m,
    input  logic       Clk,
    input  logic       nReset
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_CMP  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOT  = 4'd6,
        OP_PASS = 4'd7,
        OP_ACCA = 4'd8,
        OP_ACCS = 4'd9,
        OP_SHL  = 4'd10,
        OP_SHR  = 4'd11,
        OP_INC  = 4'd12,
        OP_DEC  = 4'd13,
        OP_HOLD = 4'd14,
        OP_CLR  = 4'd15
    } op_t;

    op_t        op;
    logic [4:0] ea;
    logic [4:0] eb;
    logic [4:0] er;
    logic [4:0] ec;
    logic [4:0] nxt;

    assign op = op_t'(m);
    assign ea = {1'b0, a};
    assign eb = {1'b0, b};
    assign er = {1'b0, r};
    assign ec = {4'b0, cin};

    // nxt = {of_next, r_next}; bit 4 of a 5-bit sum/difference is carry/borrow
    always_comb begin
        nxt = 5'b0;
        unique case (op)
            OP_ADD:  nxt = ea + eb + ec;
            OP_SUB:  nxt = ea - eb - ec;
            OP_CMP:  nxt = {2'b0, a < b, a > b, a == b};
            OP_AND:  nxt = {1'b0, a & b};
            OP_OR:   nxt = {1'b0, a | b};
            OP_XOR:  nxt = {1'b0, a ^ b};
            OP_NOT:  nxt = {1'b0, ~a};
            OP_PASS: nxt = {1'b0, a};
            OP_ACCA: nxt = er + ea + ec;
            OP_ACCS: nxt = er - ea - ec;
            OP_SHL:  nxt = {a[3], a[2:0], cin};
            OP_SHR:  nxt = {a[0], cin, a[3:1]};
            OP_INC:  nxt = ea + 5'd1;
            OP_DEC:  nxt = ea - 5'd1;
            OP_HOLD: nxt = {of, r};
            OP_CLR:  nxt = 5'b0;
            default: nxt = 5'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r  <= 4'b0;
            of <= 1'b0;
        end else begin
            r  <= nxt[3:0];
            of <= nxt[4];
        end
    end

endmodule

// File: tb/tb_accum5.sv
// tb_accum5: directed vectors for accum5.
// Checks {of, r} one clock after each op is applied.
module tb_accum5;

    logic [3:0] r;
    logic       of;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] m;
    logic       Clk;
    logic       nReset;

    int nvec = 0;
    int nbad = 0;

    accum5 dut (
        .r      (r),
        .of     (of),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .m      (m),
        .Clk    (Clk),
        .nReset (nReset)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag,
                       input logic [4:0] got,
                       input logic [4:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got of,r=%b_%b want %b_%b",
                     tag, got[4], got[3:0], exp[4], exp[3:0]);
        end
    endtask

    // apply op, clock it, check {of,r} just after the edge
    task automatic op(input string tag, input logic [3:0] mm,
                      input logic [3:0] aa, input logic [3:0] bb,
                      input logic cc, input logic [4:0] exp);
        m   = mm;
        a   = aa;
        b   = bb;
        cin = cc;
        @(posedge Clk);
        #1;
        chk(tag, {of, r}, exp);
    endtask

    initial begin
        nReset = 1'b0;
        a = 4'h0;
        b = 4'h0;
        cin = 1'b0;
        m = 4'd7;
        #1;
        chk("reset_async", {of, r}, 5'b0_0000);
        @(posedge Clk);
        #1;
        chk("reset_held", {of, r}, 5'b0_0000);
        nReset = 1'b1;

        op("add_wrap", 4'd0, 4'b1111, 4'b0001, 0, 5'b1_0000);
        op("add_nc",   4'd0, 4'b1010, 4'b0101, 0, 5'b0_1111);
        op("add_c",    4'd0, 4'b0111, 4'b1100, 0, 5'b1_0011);
        op("add_cin",  4'd0, 4'b0111, 4'b0001, 1, 5'b0_1001);
        op("sub_a",    4'd1, 4'b1111, 4'b1001, 0, 5'b0_0110);
        op("sub_b",    4'd1, 4'b1010, 4'b0101, 0, 5'b0_0101);
        op("sub_bor",  4'd1, 4'b0111, 4'b1100, 0, 5'b1_1011);
        op("sub_cin",  4'd1, 4'b0101, 4'b0101, 1, 5'b1_1111);
        op("cmp_gt1",  4'd2, 4'b1001, 4'b0001, 1, 5'b0_0010);
        op("cmp_gt2",  4'd2, 4'b1010, 4'b0101, 0, 5'b0_0010);
        op("cmp_lt",   4'd2, 4'b0111, 4'b1100, 0, 5'b0_0100);
        op("cmp_eq",   4'd2, 4'b0011, 4'b0011, 0, 5'b0_0001);
        op("and_a",    4'd3, 4'b1001, 4'b0001, 0, 5'b0_0001);
        op("and_b",    4'd3, 4'b1010, 4'b0101, 0, 5'b0_0000);
        op("and_c",    4'd3, 4'b0111, 4'b1100, 0, 5'b0_0100);
        op("or",       4'd4, 4'b1010, 4'b0101, 0, 5'b0_1111);
        op("xor",      4'd5, 4'b0110, 4'b0011, 0, 5'b0_0101);
        op("not",      4'd6, 4'b0101, 4'b0000, 0, 5'b0_1010);
        op("pass",     4'd7, 4'b1001, 4'b1111, 1, 5'b0_1001);
        op("shl",      4'd10, 4'b1001, 4'b0000, 1, 5'b1_0011);
        op("shr",      4'd11, 4'b1001, 4'b0000, 0, 5'b1_0100);
        op("shr_fill", 4'd11, 4'b0110, 4'b0000, 1, 5'b0_1011);
        op("inc_wrap", 4'd12, 4'b1111, 4'b0000, 0, 5'b1_0000);
        op("inc",      4'd12, 4'b0011, 4'b0000, 1, 5'b0_0100);
        op("dec_wrap", 4'd13, 4'b0000, 4'b0000, 0, 5'b1_1111);
        op("dec",      4'd13, 4'b0101, 4'b0000, 1, 5'b0_0100);

        op("clr",      4'd15, 4'b1111, 4'b1111, 1, 5'b0_0000);
        op("acca_1",   4'd8, 4'b0101, 4'b0000, 0, 5'b0_0101);
        op("acca_2",   4'd8, 4'b0101, 4'b0000, 0, 5'b0_1010);
        op("acca_3",   4'd8, 4'b0101, 4'b0000, 0, 5'b0_1111);
        op("acca_4",   4'd8, 4'b0101, 4'b0000, 0, 5'b1_0100);
        op("hold_1",   4'd14, 4'b1111, 4'b1111, 1, 5'b1_0100);
        op("acca_cin", 4'd8, 4'b0010, 4'b0000, 1, 5'b0_0111);
        op("accs_1",   4'd9, 4'b0011, 4'b0000, 1, 5'b0_0011);
        op("accs_2",   4'd9, 4'b0100, 4'b0000, 0, 5'b1_1111);
        op("hold_2",   4'd14, 4'b0000, 4'b0000, 0, 5'b1_1111);

        // mid-sequence reset with r=1111 and of=1
        op("pre_rst",  4'd13, 4'b0000, 4'b0000, 0, 5'b1_1111);
        m = 4'd14;
        #2;
        nReset = 1'b0;
        #1;
        chk("rst_mid", {of, r}, 5'b0_0000);
        m = 4'd7;
        a = 4'b0111;
        @(posedge Clk);
        #1;
        chk("rst_over_op", {of, r}, 5'b0_0000);
        #2;
        nReset = 1'b1;
        op("post_rst", 4'd0, 4'b0001, 4'b0001, 0, 5'b0_0010);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nbad);
        $finish;
    end

endmodule
